// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared types and constants for the shift_ctrl block.
//   state_t   - controller states (idle, shifting a word, inter-word gap)
//   GAP_CNT_W - width of the inter-word gap counter
package shift_ctrl_pkg;

    localparam int GAP_CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/shift_ctrl_if.sv
// shift_ctrl_if: parallel-in / serial-out bus of shift_ctrl.
//   in_valid/in_ready/in_data : parallel word handshake
//   abort                     : synchronous cancel of the current word
//   serial_out/frame          : serial bit stream (MSB first) and its qualifier
//   done/busy                 : completion pulse and activity status
// master drives the word side, slave is the controller.
interface shift_ctrl_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          abort;
    logic          serial_out;
    logic          frame;
    logic          done;
    logic          busy;

    modport master (
        output in_valid, in_data, abort,
        input  in_ready, serial_out, frame, done, busy
    );

    modport slave (
        input  in_valid, in_data, abort,
        output in_ready, serial_out, frame, done, busy
    );
endinterface

// File: rtl/shift_ctrl_shiftreg.sv
// ShiftReg: parallel-load, shift-left register.
//   clk, rst_n : clock, async active-low reset (clears to 0)
//   load, d    : parallel load (wins over shift if both were ever asserted)
//   shift      : shift left one bit, serial_in enters at the LSB
//   q          : register contents
module ShiftReg #(
    parameter int  DW   = 8,
    parameter type dw_t = logic [DW-1:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic shift,
    input  logic serial_in,
    input  dw_t  d,
    output dw_t  q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (load)
            q <= d;
        else if (shift)
            q <= dw_t'({q[DW-2:0], serial_in});
    end

endmodule

// File: rtl/shift_ctrl.sv
// shift_ctrl: accepts a DW-bit word and streams it MSB first, one bit per
// cycle, followed by GAP idle cycles.
//   clk, rst_n : clock, async active-low reset
//   bus        : shift_ctrl_if slave (handshake, abort, serial stream, status)
// Word period is DW+1+GAP cycles: DW in SHIFT, GAP in GAP, one in IDLE where
// the next word is taken.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int  DW   = 8,
    parameter int  GAP  = 0,
    parameter type dw_t = logic [DW-1:0]
) (
    input  logic         clk,
    input  logic         rst_n,
    shift_ctrl_if.slave  bus
);

    localparam int BW = $clog2(DW);

    if (DW < 2)               begin : g_bad_dw  $error("shift_ctrl: DW must be >= 2");   end
    if (GAP < 0 || GAP > 15)  begin : g_bad_gap $error("shift_ctrl: GAP must be 0..15"); end

    state_t                 state, state_nx;
    logic [BW-1:0]          bit_cnt;
    logic [GAP_CNT_W-1:0]   gap_cnt;
    logic                   done_q;
    logic                   last_bit, gap_end;
    logic                   load, shift;
    dw_t                    sr_q;

    assign last_bit = (bit_cnt == BW'(DW-1));
    // Only reachable when GAP > 0, so the GAP == 0 wrap of GAP-1 is harmless.
    assign gap_end  = (gap_cnt == GAP_CNT_W'(GAP-1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Counters and done pulse. Counters advance only while their state is
    // active and clear otherwise, so abort and every exit leave them at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            bit_cnt <= shift ? bit_cnt + 1'b1 : '0;
            gap_cnt <= (state == S_GAP && !bus.abort && !gap_end) ? gap_cnt + 1'b1 : '0;
            done_q  <= (state == S_SHIFT) && last_bit && !bus.abort;
        end
    end

    // Next state; abort overrides everything
    always_comb begin
        state_nx = state;
        if (bus.abort) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (bus.in_valid) state_nx = S_SHIFT;
                S_SHIFT: if (last_bit)     state_nx = (GAP > 0) ? S_GAP : S_IDLE;
                S_GAP:   if (gap_end)      state_nx = S_IDLE;
                default:                   state_nx = S_IDLE;
            endcase
        end
    end

    // Outputs and datapath controls. load is confined to IDLE and shift to
    // SHIFT, so they can never coincide; abort suppresses both, holding data.
    always_comb begin
        bus.in_ready = (state == S_IDLE) && !bus.abort;
        load         = bus.in_ready && bus.in_valid;
        shift        = (state == S_SHIFT) && !last_bit && !bus.abort;
        bus.frame    = (state == S_SHIFT);
        bus.busy     = (state != S_IDLE);
        bus.done     = done_q;
    end

    ShiftReg #(
        .DW   (DW),
        .dw_t (dw_t)
    ) u_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .shift     (shift),
        .serial_in (1'b0),
        .d         (dw_t'(bus.in_data)),
        .q         (sr_q)
    );

    assign bus.serial_out = sr_q[DW-1];

endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: two controllers (GAP=0 and GAP=2) share one stimulus stream.
// A per-controller model tracks only "cycles since acceptance" and the word,
// from which all expected outputs follow.
module tb_shift_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          abort = 1'b0;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_ctrl_if #(.DW(DW)) if0 ();
    shift_ctrl_if #(.DW(DW)) if1 ();

    assign if0.in_valid = in_valid;
    assign if0.in_data  = in_data;
    assign if0.abort    = abort;
    assign if1.in_valid = in_valid;
    assign if1.in_data  = in_data;
    assign if1.abort    = abort;

    shift_ctrl #(.DW(DW), .GAP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    shift_ctrl #(.DW(DW), .GAP(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    logic fr[2], so[2], dn[2], bz[2], rd[2];
    assign fr[0] = if0.frame;      assign fr[1] = if1.frame;
    assign so[0] = if0.serial_out; assign so[1] = if1.serial_out;
    assign dn[0] = if0.done;       assign dn[1] = if1.done;
    assign bz[0] = if0.busy;       assign bz[1] = if1.busy;
    assign rd[0] = if0.in_ready;   assign rd[1] = if1.in_ready;

    function automatic int gap_of(int k);
        return (k == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: pos = cycles since acceptance (0 = idle). The word occupies
    // pos 1..DW on the wire, then GAP silent cycles, then idle again.
    int            pos[2];
    logic [DW-1:0] word[2];
    logic          done_e[2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                pos[k]    = 0;
                done_e[k] = 1'b0;
            end else begin
                done_e[k] = (pos[k] == DW) && !abort;
                if (abort)                          pos[k] = 0;
                else if (pos[k] == 0) begin
                    if (in_valid) begin
                        pos[k]  = 1;
                        word[k] = in_data;
                    end
                end
                else if (pos[k] >= DW + gap_of(k))  pos[k] = 0;
                else                                pos[k] = pos[k] + 1;
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic ef;
            ef = (pos[k] >= 1) && (pos[k] <= DW);
            chk($sformatf("frame%0d", k), 32'(fr[k]), 32'(ef));
            chk($sformatf("busy%0d", k),  32'(bz[k]), 32'(pos[k] != 0));
            chk($sformatf("done%0d", k),  32'(dn[k]), 32'(done_e[k]));
            chk($sformatf("ready%0d", k), 32'(rd[k]), 32'(pos[k] == 0 && !abort));
            if (ef)          chk($sformatf("serial%0d", k), 32'(so[k]), 32'(word[k][DW-pos[k]]));
            else if (!rst_n) chk($sformatf("serial_rst%0d", k), 32'(so[k]), 32'd0);
        end
    end

    // Acceptance log (taken on the falling edge, accept happens at the next rise)
    int acc0[$], acc1[$];
    always @(negedge clk) begin
        if (rst_n && in_valid && if0.in_ready) acc0.push_back(cyc);
        if (rst_n && in_valid && if1.in_ready) acc1.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((if0.busy || if1.busy) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [DW-1:0] d);
        wait_idle();
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Called in the first cycle after acceptance; watches GAP=0 controller.
    task automatic collect(output logic [DW-1:0] bits, output int nf,
                           output int done_at, output logic rdy9);
        bits = '0; nf = 0; done_at = -1; rdy9 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (if0.frame) begin
                bits = {bits[DW-2:0], if0.serial_out};
                nf++;
            end
            if (if0.done) done_at = i;
            if (i == 9) rdy9 = if0.in_ready;
            tick();
        end
    endtask

    logic [DW-1:0] bits;
    int            nf, done_at;
    logic          rdy9;

    initial begin
        // Reset values
        #2;
        chk("rst_frame", 32'(if0.frame), 32'd0);
        chk("rst_busy",  32'(if0.busy),  32'd0);
        chk("rst_done",  32'(if0.done),  32'd0);
        chk("rst_ready", 32'(if0.in_ready), 32'd1);
        chk("rst_serial", 32'(if0.serial_out), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // A5: bits, frame length, done and ready timing
        send(8'hA5);
        collect(bits, nf, done_at, rdy9);
        chk("a5_bits", 32'(bits), 32'hA5);
        chk("a5_nframe", 32'(nf), 32'd8);
        chk("a5_done_at", 32'(done_at), 32'd9);
        chk("a5_ready9", 32'(rdy9), 32'd1);

        // Back-to-back words: period DW+1 (GAP=0) and DW+1+2 (GAP=2)
        wait_idle();
        acc0.delete(); acc1.delete();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        in_data  = 8'h01;
        repeat (14) tick();
        in_valid = 1'b0;
        chk("acc0_count", 32'(acc0.size() >= 2), 32'd1);
        chk("acc1_count", 32'(acc1.size() >= 2), 32'd1);
        if (acc0.size() >= 2) chk("period_gap0", 32'(acc0[1] - acc0[0]), 32'd9);
        if (acc1.size() >= 2) chk("period_gap2", 32'(acc1[1] - acc1[0]), 32'd11);

        // Abort on the 4th frame cycle of 3C
        send(8'h3C);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        chk("abort_frame", 32'(if0.frame), 32'd0);
        chk("abort_busy",  32'(if0.busy),  32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_nodone", 32'(if0.done), 32'd0);
            tick();
        end
        send(8'h5A);
        collect(bits, nf, done_at, rdy9);
        chk("post_abort_bits", 32'(bits), 32'h5A);
        chk("post_abort_done", 32'(done_at), 32'd9);

        // abort together with in_valid in IDLE
        wait_idle();
        abort = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        #1;
        chk("abort_idle_ready", 32'(if0.in_ready), 32'd0);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        #1;
        chk("abort_idle_frame", 32'(if0.frame), 32'd0);
        chk("abort_idle_busy",  32'(if1.busy),  32'd0);

        // Asynchronous reset mid-word, then 81 right after release
        send(8'h3C);
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_frame",  32'(if0.frame), 32'd0);
        chk("arst_busy",   32'(if1.busy),  32'd0);
        chk("arst_serial", 32'(if0.serial_out), 32'd0);
        chk("arst_done",   32'(if0.done),  32'd0);
        chk("arst_ready",  32'(if0.in_ready), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h81;
        tick();
        in_valid = 1'b0;
        collect(bits, nf, done_at, rdy9);
        chk("post_rst_bits", 32'(bits), 32'h81);
        chk("post_rst_nframe", 32'(nf), 32'd8);

        // Random traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = DW'($urandom);
            abort    = ($urandom_range(0, 40) == 0);
            tick();
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 Parameter DW, default 8, shift width in bits; SHALL be >= 2.
REQ-002 Parameter GAP, default 0, idle cycles inserted after each word; SHALL be 0..15.
REQ-003 Parameter type dw_t, default logic [DW-1:0], parallel word type.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  parallel word offered.
REQ-007 in_ready  output  1  controller can accept a word this cycle.
REQ-008 in_data  input  DW  parallel word, sampled when in_valid && in_ready.
REQ-009 abort  input  1  synchronous cancel of the current word.
REQ-010 serial_out  output  1  current serial bit, MSB first.
REQ-011 frame  output  1  high while serial_out carries a valid bit.
REQ-012 done  output  1  one-cycle pulse after a word completes normally.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 States SHALL be IDLE, SHIFT and GAP; in_ready SHALL equal (state == IDLE) && !abort.
REQ-015 Accept: in IDLE with in_valid && !abort, the shift register SHALL load in_data at that edge, bit_cnt SHALL clear to 0, and the next state SHALL be SHIFT.
REQ-016 serial_out SHALL equal shift-register bit DW-1; zeros SHALL fill from the LSB during shifting.
REQ-017 In SHIFT, frame SHALL be 1; if bit_cnt < DW-1, the register SHALL shift left one bit and bit_cnt SHALL increment at the edge.
REQ-018 In SHIFT with bit_cnt == DW-1, the next state SHALL be GAP if GAP > 0, else IDLE; done SHALL be 1 in the following cycle only.
REQ-019 frame SHALL be high for exactly DW consecutive cycles per accepted word, starting the cycle after acceptance.
REQ-020 GAP state SHALL last exactly GAP cycles, counted by gap_cnt, then return to IDLE; frame SHALL be 0 in GAP.
REQ-021 Word period SHALL be DW+1+GAP cycles from acceptance to the next earliest acceptance.
REQ-022 Load and shift SHALL never be asserted to the shift register in the same cycle.
REQ-023 abort SHALL have priority over every other input: in any state the next state SHALL be IDLE, with bit_cnt and gap_cnt cleared and no done pulse.
REQ-024 abort in IDLE with in_valid high SHALL NOT accept the word.
REQ-025 When abort is asserted, the shift-register contents SHALL be held as they are; serial_out is don't-care while frame is 0.
REQ-026 in_data and in_valid changes while busy SHALL have no effect.
REQ-027 bit_cnt width SHALL be $clog2(DW); gap_cnt width SHALL be 4 bits; neither counter SHALL wrap.

Reset
REQ-028 On rst_n low, regardless of clk, state SHALL be IDLE, bit_cnt and gap_cnt SHALL be 0, and the shift register SHALL be 0.
REQ-029 During reset: frame=0, done=0, busy=0, serial_out=0, in_ready=1 (unless abort is high).
REQ-030 Reset asserted mid-word SHALL discard the word without a done pulse; the first acceptance SHALL be possible in the first cycle after release.

Structure
REQ-031 Package shift_ctrl_pkg SHALL hold the state enum type (IDLE, SHIFT, GAP) and the GAP counter width constant.
REQ-032 The datapath SHALL be one instance of the team's ShiftReg module (DW and dw_t passed through, serial_in tied to 0); the FSM and counters SHALL be in shift_ctrl.

Verification
REQ-033 DW=8, GAP=0, in_data=8'hA5 accepted at cycle 0 -> serial_out 1,0,1,0,0,1,0,1 with frame high in cycles 1-8, done in cycle 9, in_ready in cycle 9.
REQ-034 in_valid held high with words 8'hFF and 8'h01 -> second acceptance exactly 9 cycles after the first; bit streams contiguous apart from the single IDLE cycle.
REQ-035 GAP=2, in_valid held high -> frame low for 3 cycles between words (GAP, GAP, IDLE/accept); period 11 cycles.
REQ-036 abort on the 4th frame cycle of 8'h3C -> IDLE next cycle, no done, frame low, next word accepted normally with correct bits.
REQ-037 rst_n pulsed low mid-word, asynchronous to clk -> outputs reach reset values immediately, no done; word 8'h81 accepted after release streams 1,0,0,0,0,0,0,1.
REQ-038 abort and in_valid high together in IDLE -> in_ready 0, no load, frame stays 0.
